// File: rtl/sa_pkg.sv
// ---------------------------------------------------------------------------
// sa_pkg
// Shared definitions for the systolic-array controller:
//   - sa_state_e    : controller FSM states
//   - SA_DATA_WIDTH : default element width of weights, inputs and results
//   - W*_IDX        : element positions of each weight inside the packed
//                     w_data word {w11,w10,w01,w00}, w00 in the LSBs
// ---------------------------------------------------------------------------
package sa_pkg;

    localparam int SA_DATA_WIDTH = 8;

    localparam int W00_IDX = 0;
    localparam int W01_IDX = 1;
    localparam int W10_IDX = 2;
    localparam int W11_IDX = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } sa_state_e;

endpackage

// File: rtl/sa_result_fifo.sv
// ---------------------------------------------------------------------------
// sa_result_fifo
// Synchronous first-word-fall-through FIFO that holds {y1,y0} result pairs.
// The head entry is visible on pop_data whenever the FIFO is non-empty; it
// reads as zero while empty.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   push, push_data     : write request and data (ignored when full)
//   pop                 : remove head entry (ignored when empty)
//   pop_data            : head entry
//   full, empty, count  : occupancy status
// ---------------------------------------------------------------------------
module sa_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // NOTE: the storage array has no reset; only pointers and count do.
    // Stale entries are unreachable because pop_data is gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_ctrl
// Controller for a 2x2 weight-stationary systolic array. Loads a weight set,
// streams batch_len input vectors into the array with x1 skewed one cycle
// behind x0, captures the matching y0/y1 outputs, and queues the pairs in a
// credit-protected result FIFO.
// Ports:
//   clk, reset                   : clock, asynchronous active-high reset
//   w_valid/w_ready/w_data       : weight handshake, {w11,w10,w01,w00}
//   batch_len                    : vectors per batch, sampled at weight accept
//   in_valid/in_ready/in_x0/in_x1: input vector handshake
//   arr_*                        : array-side weights, inputs, results, control
//   out_valid/out_ready/out_y*   : result handshake (issue order)
//   done                         : one-cycle pulse at the end of each batch
//   perf_cycles/perf_stalls      : only with SYSTOLIC_CTRL_PERF_EN defined
// ---------------------------------------------------------------------------
module systolic_ctrl
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = SA_DATA_WIDTH,
    parameter int ARRAY_LAT  = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [4*DATA_WIDTH-1:0] w_data,
    input  logic [7:0]              batch_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_x0,
    input  logic [DATA_WIDTH-1:0]   in_x1,
    output logic                    arr_load_weights,
    output logic                    arr_start,
    output logic [DATA_WIDTH-1:0]   arr_w00,
    output logic [DATA_WIDTH-1:0]   arr_w01,
    output logic [DATA_WIDTH-1:0]   arr_w10,
    output logic [DATA_WIDTH-1:0]   arr_w11,
    output logic [DATA_WIDTH-1:0]   arr_x0,
    output logic [DATA_WIDTH-1:0]   arr_x1,
    input  logic [DATA_WIDTH-1:0]   arr_y0,
    input  logic [DATA_WIDTH-1:0]   arr_y1,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_y0,
    output logic [DATA_WIDTH-1:0]   out_y1,
    output logic                    done
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]             perf_cycles,
    output logic [31:0]             perf_stalls
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    sa_state_e                 state_q;
    logic [4*DATA_WIDTH-1:0]   w_q;
    logic [7:0]                batch_len_q;
    logic [7:0]                issued_q;
    logic [7:0]                issued_d;
    logic                      w_ready_q;
    logic                      load_q;
    logic                      start_q;
    logic                      done_q;

    logic [CW-1:0]             credits_q;
    logic [CW-1:0]             credits_d;
    logic [ARRAY_LAT:0]        vld_q;      // bit k set: a vector issued k+1 cycles ago
    logic [DATA_WIDTH-1:0]     x1_q;
    logic [DATA_WIDTH-1:0]     y0_hold_q;

    logic                      issue;
    logic                      pop;
    logic                      drained;
    logic                      fifo_push;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CW-1:0]             fifo_count;
    logic [2*DATA_WIDTH-1:0]   fifo_head;

    assign in_ready = (state_q == STREAM) && (credits_q != '0) && (issued_q < batch_len_q);
    assign issue    = in_valid && in_ready;
    assign issued_d = issued_q + {7'd0, issue};
    assign pop      = out_valid && out_ready;
    assign drained  = (vld_q == '0) && (fifo_count == '0);

    // ---------------- controller FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            w_q         <= '0;
            batch_len_q <= '0;
            issued_q    <= '0;
            w_ready_q   <= 1'b1;
            load_q      <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every register samples the
            // pre-edge values; blocking = here would chain updates in order.
            load_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_valid) begin
                        w_q         <= w_data;
                        batch_len_q <= batch_len;
                        issued_q    <= '0;
                        w_ready_q   <= 1'b0;
                        load_q      <= 1'b1;
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    start_q <= 1'b1;
                    state_q <= STREAM;
                end
                STREAM: begin
                    issued_q <= issued_d;
                    // Leave on the cycle of the last issue (or at once for an
                    // empty batch) so no idle STREAM cycle is spent.
                    if (issued_d == batch_len_q) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (drained) begin
                        start_q   <= 1'b0;
                        done_q    <= 1'b1;
                        w_ready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ---------------- credits, skew and capture ----------------
    always_comb begin
        // NOTE: default assignment first keeps this combinational (no latch).
        credits_d = credits_q;
        if (issue && !pop)      credits_d = credits_q - CW'(1);
        else if (pop && !issue) credits_d = credits_q + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits_q <= CW'(FIFO_DEPTH);
            vld_q     <= '0;
            x1_q      <= '0;
            y0_hold_q <= '0;
        end else begin
            credits_q <= credits_d;
            vld_q     <= {vld_q[ARRAY_LAT-1:0], issue};
            x1_q      <= issue ? in_x1 : '0;
            // y0 of a vector arrives one cycle ahead of its y1; hold it so the
            // pair is written together when y1 is sampled.
            if (vld_q[ARRAY_LAT-1]) y0_hold_q <= arr_y0;
        end
    end

    // Credits already bound occupancy; the full guard is purely defensive.
    assign fifo_push = vld_q[ARRAY_LAT] && !fifo_full;

    sa_result_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({arr_y1, y0_hold_q}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign w_ready          = w_ready_q;
    assign arr_load_weights = load_q;
    assign arr_start        = start_q;
    assign done             = done_q;
    assign arr_w00          = w_q[W00_IDX*DATA_WIDTH +: DATA_WIDTH];
    assign arr_w01          = w_q[W01_IDX*DATA_WIDTH +: DATA_WIDTH];
    assign arr_w10          = w_q[W10_IDX*DATA_WIDTH +: DATA_WIDTH];
    assign arr_w11          = w_q[W11_IDX*DATA_WIDTH +: DATA_WIDTH];
    assign arr_x0           = issue ? in_x0 : '0;
    assign arr_x1           = x1_q;
    assign out_valid        = !fifo_empty;
    assign out_y0           = fifo_head[DATA_WIDTH-1:0];
    assign out_y1           = fifo_head[2*DATA_WIDTH-1:DATA_WIDTH];

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_stalls_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else if (state_q == IDLE && w_valid) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (state_q != IDLE) perf_cycles_q <= perf_cycles_q + 32'd1;
            if (state_q == STREAM && in_valid && !in_ready) perf_stalls_q <= perf_stalls_q + 32'd1;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the element width of weights, inputs and results.
REQ-002 SHALL have parameter ARRAY_LAT, default 3, meaning the cycles from x0 issue to the matching y0 at the array.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning the number of result-FIFO entries; it SHALL be at least ARRAY_LAT+2.
REQ-004 SHALL have ports: clk input 1, the sole clock; reset input 1, asynchronous active-high.
REQ-005 SHALL have ports: w_valid in 1, w_ready out 1, w_data in 4*DATA_WIDTH; w_data packs {w11,w10,w01,w00}, LSB first.
REQ-006 SHALL have ports: batch_len in 8, the vector count per batch, sampled at weight accept; in_valid in 1, in_ready out 1, in_x0 in DATA_WIDTH, in_x1 in DATA_WIDTH.
REQ-007 SHALL have array-side ports: arr_load_weights out 1, arr_start out 1, arr_w00/arr_w01/arr_w10/arr_w11 out DATA_WIDTH each, arr_x0 out DATA_WIDTH, arr_x1 out DATA_WIDTH, arr_y0 in DATA_WIDTH, arr_y1 in DATA_WIDTH.
REQ-008 SHALL have ports: out_valid out 1, out_ready in 1, out_y0 out DATA_WIDTH, out_y1 out DATA_WIDTH, done out 1.

Function
REQ-009 SHALL implement FSM states IDLE, LOAD, STREAM, DRAIN.
REQ-010 IDLE: w_ready=1; on w_valid, latch w_data and batch_len, then go to LOAD.
REQ-011 LOAD: assert arr_load_weights for exactly 1 cycle with latched weights on arr_w*; go to STREAM next cycle.
REQ-012 STREAM: in_ready = (credits>0) and (issued<batch_len); each handshake issues one vector and decrements credits.
REQ-013 Skew: arr_x0 SHALL carry in_x0 in the issue cycle; arr_x1 SHALL carry in_x1 one cycle later; arr_x0 and arr_x1 SHALL be 0 when no data is issued on them.
REQ-014 arr_start SHALL be high from the LOAD exit until the DRAIN exit.
REQ-015 Capture: arr_y0 SHALL be sampled ARRAY_LAT cycles after issue and arr_y1 ARRAY_LAT+1 cycles after issue, using valid shift pipelines; the pair SHALL be written as one FIFO entry once the y1 sample is taken.
REQ-016 Credits SHALL reset to FIFO_DEPTH, decrement on issue, and increment on FIFO pop; simultaneous issue and pop SHALL leave credits unchanged; the FIFO SHALL never overflow.
REQ-017 out_valid SHALL equal FIFO non-empty; a pop SHALL occur on out_valid and out_ready; output data SHALL be held while stalled.
REQ-018 STREAM SHALL go to DRAIN when issued==batch_len; a batch_len of 0 SHALL go directly to DRAIN.
REQ-019 DRAIN SHALL wait until all in-flight results are written and the FIFO is empty, then pulse done for 1 cycle and return to IDLE.
REQ-020 Results SHALL be passed through unmodified with no arithmetic; the order SHALL equal issue order.

Reset
REQ-021 Asynchronous reset SHALL force: state IDLE; every control output 0, except w_ready, which SHALL be 1 when reset deasserts; all data outputs 0; credits FIFO_DEPTH; FIFO emptied; pipelines cleared.
REQ-022 Reset mid-batch SHALL discard in-flight results and SHALL NOT pulse done.

Configuration
REQ-023 SHALL use the macro SYSTOLIC_CTRL_PERF_EN; when it is defined, the block SHALL add outputs perf_cycles[31:0] and perf_stalls[31:0].
REQ-024 perf_cycles SHALL count cycles spent outside IDLE; perf_stalls SHALL count STREAM cycles with in_valid=1 and in_ready=0; both SHALL clear on reset and on weight accept.
REQ-025 When the macro is undefined, the ports and counters SHALL be absent, with otherwise identical behaviour.

Structure
REQ-026 Package sa_pkg SHALL hold the FSM state enum, the DATA_WIDTH default, and the weight-packing offset constants.
REQ-027 The result FIFO SHALL be the sub-module sa_result_fifo, a synchronous FIFO with first-word fall-through and full/empty/count outputs.

Verification
REQ-028 Weights {4,3,2,1}, batch_len=1, x=(5,6): arr_load_weights pulses once; arr_x1=6 one cycle after arr_x0=5; model y0=ARRAY_LAT-delayed stub result appears on out_y0; done pulses once.
REQ-029 batch_len=16 with out_ready=0: in_ready drops after 8 issues; no FIFO overflow; releasing out_ready yields 16 results in order.
REQ-030 batch_len=0: FSM goes IDLE->LOAD->STREAM->DRAIN->IDLE; done pulses; out_valid never asserts.
REQ-031 Continuous pop with issue on the same cycle at credits=1: credits stay 1 and throughput is 1 vector/cycle.
REQ-032 Reset asserted at the 3rd issue of batch_len=5: outputs return to reset values, no done pulse, and the next batch runs cleanly.
REQ-033 With SYSTOLIC_CTRL_PERF_EN defined, batch_len=4, in_valid held 1, out_ready=1: perf_stalls=0 and perf_cycles matches the cycle count of the LOAD..DRAIN span.
